// File: rtl/dram_read_burst_engine.sv
// DRAM read burst engine: turns one {addr, len} read command from the image
// sender into one or two AXI4 INCR read bursts. A second burst is needed only
// when the request crosses a 4 KB page. Returned beats are forwarded one clock
// after their R handshake.
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. AR payload (araddr/arlen) is held stable while arvalid
// is high and arready is low. rready is high for the whole of an R phase, so
// the read data channel is never backpressured.
module dram_read_burst_engine #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH    = 1
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_reset,
  // command side
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       read_error,
  // AXI4 read address channel
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  // AXI4 read data channel
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  // debug view of the FSM state
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR1  = 3'd1,
    S_R1   = 3'd2,
    S_AR2  = 3'd3,
    S_R2   = 3'd4
  } state_t;

  localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_MASK = DRAM_ADDR_WIDTH'(15);
  localparam logic [DRAM_ADDR_WIDTH-1:0] PAGE_MASK = DRAM_ADDR_WIDTH'(12'hFFF);
  localparam logic [DRAM_ADDR_WIDTH-1:0] ADDR_ONE  = DRAM_ADDR_WIDTH'(1);

  state_t                       state;
  logic [DRAM_ADDR_WIDTH-1:0]   burst2_addr;
  logic [7:0]                   burst2_len;
  logic                         split_q;
  logic [7:0]                   beat_cnt;

  logic [DRAM_ADDR_WIDTH-1:0]   addr_al;
  logic [DRAM_ADDR_WIDTH-1:0]   page_next;
  logic [7:0]                   page_beat;
  logic [8:0]                   len_sum;
  logic                         beat_final;

  // Command decode. With p = beat index inside the 4 KB page, the page holds
  // 256-p beats. The request splits when len+1 > 256-p, i.e. when len+p
  // carries out of 8 bits. In that case the low 8 bits of len+p are exactly the
  // second burst's arlen, and ~p is the first burst's arlen (255-p).
  always_comb begin
    addr_al    = dram_read_addr & ~BEAT_MASK;
    page_next  = (addr_al | PAGE_MASK) + ADDR_ONE;
    page_beat  = dram_read_addr[11:4];
    len_sum    = {1'b0, dram_read_len} + {1'b0, page_beat};
    beat_final = (beat_cnt == m_axi_arlen);
  end

  // Main FSM: command capture, AR issue, beat forwarding and error tracking.
  always_ff @(posedge clk_pixel) begin
    if (dram_reader_reset) begin
      state                <= S_IDLE;
      m_axi_araddr         <= '0;
      m_axi_arlen          <= '0;
      dram_read_data       <= '0;
      dram_read_data_valid <= 1'b0;
      read_error           <= 1'b0;
      burst2_addr          <= '0;
      burst2_len           <= '0;
      split_q              <= 1'b0;
      beat_cnt             <= '0;
    end else begin
      dram_read_data_valid <= 1'b0;
      // A new command while one is in flight is dropped and flagged.
      if (dram_read_en && (state != S_IDLE)) read_error <= 1'b1;
      case (state)
        S_IDLE: begin
          if (dram_read_en) begin
            m_axi_araddr <= addr_al;
            if (len_sum[8]) begin
              m_axi_arlen <= ~page_beat;
              burst2_addr <= page_next;
              burst2_len  <= len_sum[7:0];
              split_q     <= 1'b1;
            end else begin
              m_axi_arlen <= dram_read_len;
              split_q     <= 1'b0;
            end
            state <= S_AR1;
          end
        end
        S_AR1, S_AR2: begin
          if (m_axi_arready) begin
            beat_cnt <= '0;
            state    <= (state == S_AR1) ? S_R1 : S_R2;
          end
        end
        S_R1, S_R2: begin
          if (m_axi_rvalid) begin
            dram_read_data       <= m_axi_rdata;
            dram_read_data_valid <= 1'b1;
            if (m_axi_rresp != 2'b00) read_error <= 1'b1;
            if (m_axi_rlast != beat_final) read_error <= 1'b1;
            // The burst ends on the counted final beat regardless of rlast.
            if (beat_final) begin
              if ((state == S_R1) && split_q) begin
                m_axi_araddr <= burst2_addr;
                m_axi_arlen  <= burst2_len;
                state        <= S_AR2;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axi_arvalid  = (state == S_AR1) || (state == S_AR2);
  assign m_axi_rready   = (state == S_R1) || (state == S_R2);
  assign dram_read_busy = (state != S_IDLE);
  assign m_axi_arsize   = 3'b100;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arid     = '0;
  assign state_dbg      = state;

endmodule
